// File: rtl/seg7_bin_display_if.sv
// seg7_bin_display_if: load/value request and committed BCD result of the binary-to-display converter
interface seg7_bin_display_if #(
  parameter int BIN_WIDTH  = 6,
  parameter int NUM_DIGITS = 2
);
  logic                    load;
  logic [BIN_WIDTH-1:0]    value;
  logic                    busy;
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic                    overflow;
  modport master (output load, value, input busy, digits_bcd, overflow);
  modport slave (input load, value, output busy, digits_bcd, overflow);
endinterface

// File: rtl/seg7_bin_display.sv
// seg7_bin_display: double-dabble BCD converter driving a scanned active-low 7-seg display; SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros
module seg7_bin_display #(
  parameter int BIN_WIDTH  = 6,
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_bin_display_if.slave     bus,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  function automatic logic [63:0] max_val(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction
  localparam logic [63:0] MAX_VAL = max_val(NUM_DIGITS);
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      4'hF: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t               state, state_n;
  logic [BIN_WIDTH-1:0] bin;
  logic [DW-1:0]        bcd, bcd_adj;
  logic [CW-1:0]        cnt;
  logic                 ovf_pend;
  logic                 start;
  assign start    = state == IDLE && bus.load;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = start ? SHIFT :
              (state == SHIFT && cnt == CW'(1)) ? COMMIT :
              state == COMMIT ? IDLE : state;
  end
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk)
    if (reset) begin
      bin            <= '0;
      bcd            <= '0;
      cnt            <= '0;
      ovf_pend       <= 1'b0;
      bus.digits_bcd <= '0;
      bus.overflow   <= 1'b0;
    end else if (start) begin
      bin      <= bus.value;
      bcd      <= '0;
      cnt      <= CW'(BIN_WIDTH);
      ovf_pend <= 64'(bus.value) > MAX_VAL;
    end else if (state == SHIFT) begin
      {bcd, bin} <= {bcd_adj, bin} << 1;
      cnt        <= cnt - 1'b1;
    end else if (state == COMMIT) begin
      bus.digits_bcd <= ovf_pend ? '1 : bcd;
      bus.overflow   <= ovf_pend;
    end
  logic [PW-1:0] presc;
  logic [IW-1:0] idx, idx_n;
  logic [3:0]    nib;
  logic          blank;
  always_comb begin
    idx_n = presc == PW'(SCAN_DIV - 1) ? (idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1) : idx;
    nib   = bus.digits_bcd[{idx_n, 2'b00} +: 4];
  end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  zrun;
  // lz[i]: nibble i and every nibble above it are zero; dashes are 4'hF so never qualify
  always_comb begin
    zrun = 1'b1;
    lz   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun  = zrun && bus.digits_bcd[4*i +: 4] == 4'd0;
      lz[i] = zrun;
    end
  end
  assign blank = idx_n != '0 && lz[idx_n];
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      an    <= ~NUM_DIGITS'(1);
      seg   <= 7'b0000001;
    end else begin
      presc <= presc == PW'(SCAN_DIV - 1) ? '0 : presc + 1'b1;
      idx   <= idx_n;
      an    <= ~(NUM_DIGITS'(1) << idx_n);
      seg   <= blank ? 7'b1111111 : decode(nib);
    end
endmodule

// File: tb/tb_seg7_bin_display.sv
// tb_seg7_bin_display: directed checks of conversion timing, overflow, scanning, blanking and reset abort
module tb_seg7_bin_display;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  seg7_bin_display_if #(.BIN_WIDTH(6), .NUM_DIGITS(2)) ia();
  seg7_bin_display_if #(.BIN_WIDTH(7), .NUM_DIGITS(2)) ib();
  seg7_bin_display_if #(.BIN_WIDTH(10), .NUM_DIGITS(3)) ic();
  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] an_a, an_b;
  logic [2:0] an_c;
  seg7_bin_display #(.BIN_WIDTH(6), .NUM_DIGITS(2), .SCAN_DIV(4)) dut_a (.clk(clk), .reset(reset), .bus(ia), .seg(seg_a), .an(an_a));
  seg7_bin_display #(.BIN_WIDTH(7), .NUM_DIGITS(2), .SCAN_DIV(4)) dut_b (.clk(clk), .reset(reset), .bus(ib), .seg(seg_b), .an(an_b));
  seg7_bin_display #(.BIN_WIDTH(10), .NUM_DIGITS(3), .SCAN_DIV(4)) dut_c (.clk(clk), .reset(reset), .bus(ic), .seg(seg_c), .an(an_c));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = 7'b1111111;
`else
  localparam logic [6:0] ZB = 7'b0000001;
`endif
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ia.busy); end
    checks++; if (ia.digits_bcd !== 8'h00) begin errors++; $display("FAIL reset_digits got %h exp 00", ia.digits_bcd); end
    checks++; if (ia.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", ia.overflow); end
    checks++; if (an_a !== 2'b10) begin errors++; $display("FAIL reset_an got %b exp 10", an_a); end
    checks++; if (seg_a !== 7'b0000001) begin errors++; $display("FAIL reset_seg got %b exp 0000001", seg_a); end
    checks++; if (an_c !== 3'b110) begin errors++; $display("FAIL reset_an3 got %b exp 110", an_c); end
    reset = 1'b0;
  endtask
  task automatic test_scan;
    logic [2:0] exp;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      exp = ~(3'b001 << ((i / 4) % 3));
      checks++; if (an_c !== exp) begin errors++; $display("FAIL scan_an cyc %0d got %b exp %b", i, an_c, exp); end
      checks++; if (seg_c !== 7'b0000001) begin errors++; $display("FAIL scan_seg cyc %0d got %b exp 0000001", i, seg_c); end
      tick;
    end
  endtask
  task automatic test_convert;
    int n;
    logic [1:0] seen;
    ia.value = 6'd59;
    ia.load = 1'b1;
    tick;
    ia.load = 1'b0;
    n = 0;
    while (ia.busy && n < 20) begin n++; tick; end
    checks++; if (n !== 7) begin errors++; $display("FAIL conv_busy_cycles got %0d exp 7", n); end
    checks++; if (ia.digits_bcd !== 8'h59) begin errors++; $display("FAIL conv_digits got %h exp 59", ia.digits_bcd); end
    checks++; if (ia.overflow !== 1'b0) begin errors++; $display("FAIL conv_overflow got %b exp 0", ia.overflow); end
    tick;
    seen = 2'b00;
    for (int i = 0; i < 16; i++) begin
      if (an_a == 2'b10) seen[0] = 1'b1;
      if (an_a == 2'b01) seen[1] = 1'b1;
      checks++;
      if (!((an_a === 2'b10 && seg_a === 7'b0000100) || (an_a === 2'b01 && seg_a === 7'b0100100))) begin
        errors++; $display("FAIL conv_scan cyc %0d got an %b seg %b exp 10/0000100 or 01/0100100", i, an_a, seg_a);
      end
      tick;
    end
    checks++; if (seen !== 2'b11) begin errors++; $display("FAIL conv_scan_cover got %b exp 11", seen); end
  endtask
  task automatic test_back_to_back;
    int n;
    ia.value = 6'd59;
    ia.load = 1'b1;
    tick;
    ia.value = 6'd12;
    repeat (7) tick;
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", ia.busy); end
    checks++; if (ia.digits_bcd !== 8'h59) begin errors++; $display("FAIL b2b_ignored got %h exp 59", ia.digits_bcd); end
    tick;
    ia.load = 1'b0;
    checks++; if (ia.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", ia.busy); end
    n = 0;
    while (ia.busy && n < 20) begin n++; tick; end
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL b2b_timeout busy got %b exp 0", ia.busy); end
    checks++; if (ia.digits_bcd !== 8'h12) begin errors++; $display("FAIL b2b_second got %h exp 12", ia.digits_bcd); end
  endtask
  task automatic test_overflow;
    int n;
    ib.value = 7'd100;
    ib.load = 1'b1;
    tick;
    ib.load = 1'b0;
    n = 0;
    while (ib.busy && n < 20) begin n++; tick; end
    checks++; if (n !== 8) begin errors++; $display("FAIL ovf_busy_cycles got %0d exp 8", n); end
    checks++; if (ib.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ib.overflow); end
    checks++; if (ib.digits_bcd !== 8'hFF) begin errors++; $display("FAIL ovf_digits got %h exp FF", ib.digits_bcd); end
    tick;
    for (int i = 0; i < 8; i++) begin
      checks++; if (seg_b !== 7'b1111110) begin errors++; $display("FAIL ovf_dash cyc %0d an %b got %b exp 1111110", i, an_b, seg_b); end
      tick;
    end
    ib.value = 7'd99;
    ib.load = 1'b1;
    tick;
    ib.load = 1'b0;
    n = 0;
    while (ib.busy && n < 20) begin n++; tick; end
    checks++; if (ib.overflow !== 1'b0) begin errors++; $display("FAIL ovf99_flag got %b exp 0", ib.overflow); end
    checks++; if (ib.digits_bcd !== 8'h99) begin errors++; $display("FAIL ovf99_digits got %h exp 99", ib.digits_bcd); end
    tick;
    for (int i = 0; i < 8; i++) begin
      checks++; if (seg_b !== 7'b0000100) begin errors++; $display("FAIL ovf99_seg cyc %0d an %b got %b exp 0000100", i, an_b, seg_b); end
      tick;
    end
  endtask
  task automatic test_blank;
    int n;
    logic [6:0] exp;
    ic.value = 10'd7;
    ic.load = 1'b1;
    tick;
    ic.load = 1'b0;
    n = 0;
    while (ic.busy && n < 20) begin n++; tick; end
    checks++; if (ic.digits_bcd !== 12'h007) begin errors++; $display("FAIL blank7_digits got %h exp 007", ic.digits_bcd); end
    tick;
    for (int i = 0; i < 12; i++) begin
      case (an_c)
        3'b110: exp = 7'b0001111;
        3'b101, 3'b011: exp = ZB;
        default: exp = 7'bxxxxxxx;
      endcase
      checks++; if (seg_c !== exp) begin errors++; $display("FAIL blank7_seg an %b got %b exp %b", an_c, seg_c, exp); end
      tick;
    end
    ic.value = 10'd0;
    ic.load = 1'b1;
    tick;
    ic.load = 1'b0;
    n = 0;
    while (ic.busy && n < 20) begin n++; tick; end
    checks++; if (ic.digits_bcd !== 12'h000) begin errors++; $display("FAIL blank0_digits got %h exp 000", ic.digits_bcd); end
    tick;
    for (int i = 0; i < 12; i++) begin
      case (an_c)
        3'b110: exp = 7'b0000001;
        3'b101, 3'b011: exp = ZB;
        default: exp = 7'bxxxxxxx;
      endcase
      checks++; if (seg_c !== exp) begin errors++; $display("FAIL blank0_seg an %b got %b exp %b", an_c, seg_c, exp); end
      tick;
    end
  endtask
  task automatic test_reset_abort;
    ia.value = 6'd45;
    ia.load = 1'b1;
    tick;
    ia.load = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", ia.busy); end
    checks++; if (ia.digits_bcd !== 8'h00) begin errors++; $display("FAIL abort_digits got %h exp 00", ia.digits_bcd); end
    checks++; if (ia.overflow !== 1'b0) begin errors++; $display("FAIL abort_overflow got %b exp 0", ia.overflow); end
    checks++; if (an_a !== 2'b10) begin errors++; $display("FAIL abort_an got %b exp 10", an_a); end
    checks++; if (seg_a !== 7'b0000001) begin errors++; $display("FAIL abort_seg got %b exp 0000001", seg_a); end
    repeat (10) tick;
    checks++; if (ia.digits_bcd !== 8'h00) begin errors++; $display("FAIL abort_late_commit got %h exp 00", ia.digits_bcd); end
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL abort_late_busy got %b exp 0", ia.busy); end
  endtask
  initial begin
    ia.load = 1'b0; ia.value = '0;
    ib.load = 1'b0; ib.value = '0;
    ic.load = 1'b0; ic.value = '0;
    test_reset;
    test_scan;
    test_convert;
    test_back_to_back;
    test_overflow;
    test_blank;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
